// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types for the parametrised SPI master.
//   state_t    : transfer sequencing IDLE -> FRONT -> ACTIVE -> BACK -> IDLE
//   spi_mode_t : {cpol, cpha}, bit order matches the 2-bit mode port
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRONT  = 2'd1,
    ACTIVE = 2'd2,
    BACK   = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE_RESET = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Divider counter that paces one SCLK bit period (FULL = 2**DIV_W clk).
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   clr         : force the counter to 0 (priority over en)
//   en          : advance the counter, wrapping modulo FULL
//   div         : current count
//   lead_pt     : single-cycle strobe while div == HALF-1
//   trail_pt    : single-cycle strobe while div == FULL-1
//   sclk_phase  : div MSB, i.e. 1 in the second half of a bit period
// ---------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int DIV_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [DIV_W-1:0] div,
  output logic             lead_pt,
  output logic             trail_pt,
  output logic             sclk_phase
);

  localparam logic [DIV_W-1:0] HALF_M1 = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] FULL_M1 = {DIV_W{1'b1}};

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign div        = div_q;
  assign lead_pt    = (div_q == HALF_M1);
  assign trail_pt   = (div_q == FULL_M1);
  assign sclk_phase = div_q[DIV_W-1];

endmodule

// File: rtl/spi_mstr_param.sv
// ---------------------------------------------------------------------------
// spi_mstr_param
// Parametrised SPI master: DATA_W-bit words, SCLK period 2**DIV_W clk,
// CPOL/CPHA chosen per transfer, NUM_SS one-hot active-low slave selects.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   wrt       : start request, accepted only while idle (busy == 0)
//   cmd       : word to transmit, captured on an accepted wrt
//   mode      : {CPOL, CPHA}, captured on an accepted wrt
//   ss_sel    : slave index, captured on an accepted wrt (>= NUM_SS selects none)
//   MISO      : serial data from the slave
//   rd_data   : received word, valid from done rise until the next accepted wrt
//   done      : set at transfer end, cleared by an accepted wrt
//   busy      : high from an accepted wrt until done rises
//   SS_n      : registered active-low slave selects
//   SCLK      : registered serial clock
//   MOSI      : serial data to the slave
// Build option:
//   SPI_MSTR_LSB_FIRST_EN : when defined, words go out and come in LSB first;
//                           otherwise MSB first.
// ---------------------------------------------------------------------------
module spi_mstr_param
  import spi_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DIV_W  = 5,
  parameter  int NUM_SS = 1,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              MISO,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  spi_mode_t         mode_q, mode_d;
  logic [SS_W-1:0]   ss_sel_q, ss_sel_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              miso_smpl_q, miso_smpl_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;

  logic              div_clr;
  logic              div_en;
  logic [DIV_W-1:0]  div;
  logic              lead_pt;
  logic              trail_pt;
  logic              sclk_phase;

  // One shift step in the configured bit order; the new bit enters at the
  // end opposite to the one driving MOSI.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                 input logic              b);
`ifdef SPI_MSTR_LSB_FIRST_EN
    return {b, r[DATA_W-1:1]};
`else
    return {r[DATA_W-2:0], b};
`endif
  endfunction

  // The divider is held at 0 while idle and restarts when the half-period
  // front porch hands over to the first bit period.
  assign div_en = (state_q != IDLE);

  spi_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (div_clr),
    .en         (div_en),
    .div        (div),
    .lead_pt    (lead_pt),
    .trail_pt   (trail_pt),
    .sclk_phase (sclk_phase)
  );

  // Sequencing, data path and status flags. With CPHA=0 a bit is sampled on
  // the leading edge and shifted on the trailing edge; with CPHA=1 it is the
  // other way round, so the shift of the last sampled bit spills into the
  // first BACK cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rd_data_d   = rd_data_q;
    mode_d      = mode_q;
    ss_sel_d    = ss_sel_q;
    bitcnt_d    = bitcnt_q;
    miso_smpl_d = miso_smpl_q;
    done_d      = done_q;
    busy_d      = busy_q;
    div_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        div_clr = 1'b1;
        if (wrt) begin
          shreg_d  = cmd;
          mode_d   = spi_mode_t'(mode);
          ss_sel_d = ss_sel;
          bitcnt_d = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = FRONT;
        end
      end

      FRONT: begin
        if (lead_pt) begin
          div_clr = 1'b1;
          state_d = ACTIVE;
        end
      end

      ACTIVE: begin
        if (lead_pt) begin
          if (!mode_q.cpha) begin
            miso_smpl_d = MISO;
          end else if (bitcnt_q != '0) begin
            shreg_d = shift_in(shreg_q, miso_smpl_q);
          end
        end
        if (trail_pt) begin
          if (mode_q.cpha) begin
            miso_smpl_d = MISO;
          end else begin
            shreg_d = shift_in(shreg_q, miso_smpl_q);
          end
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = BACK;
          end
        end
      end

      BACK: begin
        if (mode_q.cpha && (div == '0)) begin
          shreg_d = shift_in(shreg_q, miso_smpl_q);
        end
        if (lead_pt) begin
          rd_data_d = shreg_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SCLK and SS_n are registered, so they are computed from the values the
  // state and divider will hold next cycle. Inside ACTIVE the next phase is
  // the current one, set by the leading strobe and cleared by the wrap.
  always_comb begin
    sclk_d = mode_d.cpol;
    if ((state_q == ACTIVE) && (state_d == ACTIVE) &&
        (lead_pt || (sclk_phase && !trail_pt))) begin
      sclk_d = !mode_d.cpol;
    end

    ss_n_d = '1;
    if (state_d != IDLE) begin
      for (int i = 0; i < NUM_SS; i++) begin
        if (ss_sel_d == SS_W'(i)) begin
          ss_n_d[i] = 1'b0;
        end
      end
    end
  end

  // All state in one place; reset returns every output to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rd_data_q   <= '0;
      mode_q      <= MODE_RESET;
      ss_sel_q    <= '0;
      bitcnt_q    <= '0;
      miso_smpl_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= '1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rd_data_q   <= rd_data_d;
      mode_q      <= mode_d;
      ss_sel_q    <= ss_sel_d;
      bitcnt_q    <= bitcnt_d;
      miso_smpl_q <= miso_smpl_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
    end
  end

  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
`ifdef SPI_MSTR_LSB_FIRST_EN
  assign MOSI    = shreg_q[0];
`else
  assign MOSI    = shreg_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_mstr_param.sv
// ---------------------------------------------------------------------------
// tb_spi_mstr_param
// Drives spi_mstr_param (DATA_W=16, DIV_W=5, NUM_SS=3) through table-driven
// and random transfers. A behavioural slave reacts to SCLK edges per
// CPOL/CPHA, and the expected SCLK/SS_n/busy/done waveforms are derived
// from the transfer timeline with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_mstr_param;

  localparam int DW    = 16;
  localparam int DIVW  = 5;
  localparam int NSS   = 3;
  localparam int SSW   = 2;
  localparam int FULL  = 1 << DIVW;
  localparam int HALF  = FULL / 2;
  localparam int TOTAL = HALF + DW * FULL + HALF;

  typedef struct {
    logic [DW-1:0]  cmd;
    logic [1:0]     mode;
    logic [SSW-1:0] sel;
    logic [DW-1:0]  miso_word;
    logic [DW-1:0]  exp_rd;
    int             exp_lat;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           wrt;
  logic [DW-1:0]  cmd;
  logic [1:0]     mode;
  logic [SSW-1:0] ss_sel;
  logic           MISO = 1'b0;
  logic [DW-1:0]  rd_data;
  logic           done;
  logic           busy;
  logic [NSS-1:0] SS_n;
  logic           SCLK;
  logic           MOSI;

  int checks = 0;
  int errors = 0;

  // model state written by the stimulus side
  logic           mon_on = 1'b0;
  int             start_id = 0;
  logic           m_cpol, m_cpha;
  logic [SSW-1:0] m_sel;
  logic [DW-1:0]  m_word;

  // model state written by the monitor side
  int             seen_id = 0;
  int             mon_t = 0;
  int             slv_k = 0;
  int             leads = 0;
  int             shape_err = 0;
  logic [DW-1:0]  rx = '0;
  logic           prev_sclk = 1'b0;
  logic [NSS-1:0] exp_ss;
  logic           exp_sclk;

  vec_t vecs[7];
  vec_t next_v;
  vec_t rv;

  spi_mstr_param #(
    .DATA_W (DW),
    .DIV_W  (DIVW),
    .NUM_SS (NSS)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .mode    (mode),
    .ss_sel  (ss_sel),
    .MISO    (MISO),
    .rd_data (rd_data),
    .done    (done),
    .busy    (busy),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k-th bit on the wire for a word, in the configured order
  function automatic logic bit_of(input logic [DW-1:0] w, input int k);
`ifdef SPI_MSTR_LSB_FIRST_EN
    return w[k];
`else
    return w[DW-1-k];
`endif
  endfunction

  // append a received wire bit to a word being rebuilt
  function automatic logic [DW-1:0] add_bit(input logic [DW-1:0] w, input logic b);
`ifdef SPI_MSTR_LSB_FIRST_EN
    return {b, w[DW-1:1]};
`else
    return {w[DW-2:0], b};
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model and slave. t counts clk edges since the accepting edge:
  // front porch t<HALF, bit periods of FULL, back porch, done at t==TOTAL.
  always @(negedge clk) begin
    if (mon_on) begin
      if (start_id != seen_id) begin
        seen_id   = start_id;
        mon_t     = 0;
        slv_k     = 0;
        leads     = 0;
        shape_err = 0;
        rx        = '0;
      end

      exp_ss = '1;
      if (mon_t < TOTAL && int'(m_sel) < NSS) exp_ss[int'(m_sel)] = 1'b0;
      if (mon_t < HALF || mon_t >= HALF + DW * FULL) exp_sclk = m_cpol;
      else exp_sclk = m_cpol ^ (((mon_t - HALF) % FULL) >= HALF);
      if ({SS_n, SCLK, busy, done} !== {exp_ss, exp_sclk, (mon_t < TOTAL), (mon_t >= TOTAL)}) begin
        shape_err++;
        if (shape_err <= 3)
          $display("[TB] waveform deviation t=%0d SS_n=%b SCLK=%b busy=%b done=%b want %b %b %b %b",
                   mon_t, SS_n, SCLK, busy, done, exp_ss, exp_sclk, (mon_t < TOTAL), (mon_t >= TOTAL));
      end

      if (mon_t == 0) begin
        prev_sclk = SCLK;
        if (!m_cpha) MISO = bit_of(m_word, 0);
      end else begin
        if (prev_sclk == m_cpol && SCLK != m_cpol) begin
          leads++;
          if (!m_cpha) begin
            rx = add_bit(rx, MOSI);
          end else if (slv_k < DW) begin
            MISO = bit_of(m_word, slv_k);
            slv_k++;
          end
        end else if (prev_sclk != m_cpol && SCLK == m_cpol) begin
          if (!m_cpha) begin
            slv_k++;
            if (slv_k < DW) MISO = bit_of(m_word, slv_k);
          end else begin
            rx = add_bit(rx, MOSI);
          end
        end
        prev_sclk = SCLK;
      end
      mon_t++;
    end
  end

  // One transfer. pre: the accepting edge has just happened (chained start).
  // poke_at: clk count at which a stray wrt with other operands is pulsed.
  // chain: hold wrt with next_v operands so it is sampled on the done edge.
  task automatic applyStimulus(input vec_t v, input int poke_at, input bit chain, input bit pre);
    int n;
    bit seen;
    if (!pre) begin
      @(negedge clk);
      cmd = v.cmd; mode = v.mode; ss_sel = v.sel; wrt = 1'b1;
      @(posedge clk);
      #1;
    end
    wrt    = 1'b0;
    m_cpol = v.mode[1];
    m_cpha = v.mode[0];
    m_sel  = v.sel;
    m_word = v.miso_word;
    start_id++;
    mon_on = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TOTAL + 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
      end else if (n == poke_at) begin
        wrt = 1'b1; cmd = 16'hFFFF; mode = ~v.mode; ss_sel = ~v.sel;
      end else if (n == poke_at + 1) begin
        wrt = 1'b0;
      end else if (chain && n == TOTAL - 1) begin
        wrt = 1'b1; cmd = next_v.cmd; mode = next_v.mode; ss_sel = next_v.sel;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("latency", n, v.exp_lat);
    @(negedge clk);
    #1;
    checkOutput("waveform", shape_err, 0);
    checkOutput("sclk_leads", leads, DW);
    checkOutput("mosi_word", 32'(rx), 32'(v.cmd));
    checkOutput("rd_data", 32'(rd_data), 32'(v.exp_rd));
    if (!chain) mon_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'hA5C3, 2'b00, 2'd0, 16'h3C5A, 16'h3C5A, TOTAL};
    vecs[1] = '{16'h8001, 2'b01, 2'd0, 16'h1234, 16'h1234, TOTAL};
    vecs[2] = '{16'h8001, 2'b10, 2'd1, 16'h1234, 16'h1234, TOTAL};
    vecs[3] = '{16'h8001, 2'b11, 2'd2, 16'h1234, 16'h1234, TOTAL};
    vecs[4] = '{16'h5AF0, 2'b00, 2'd3, 16'h0F0F, 16'h0F0F, TOTAL};
    vecs[5] = '{16'hFFFF, 2'b11, 2'd1, 16'h0000, 16'h0000, TOTAL};
    vecs[6] = '{16'h0001, 2'b10, 2'd2, 16'h8000, 16'h8000, TOTAL};

    rst = 1'b1; wrt = 1'b0; cmd = '0; mode = 2'b00; ss_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_ss_n", 32'(SS_n), 32'h7);
    checkOutput("reset_sclk", 32'(SCLK), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], -1, 1'b0, 1'b0);

    $display("[TB] random transfers");
    for (int i = 0; i < 6; i++) begin
      rv.cmd       = 16'($urandom);
      rv.mode      = 2'($urandom_range(0, 3));
      rv.sel       = 2'($urandom_range(0, 3));
      rv.miso_word = 16'($urandom);
      rv.exp_rd    = rv.miso_word;
      rv.exp_lat   = TOTAL;
      applyStimulus(rv, -1, 1'b0, 1'b0);
    end

    $display("[TB] wrt while busy is ignored");
    rv = '{16'h0000, 2'b00, 2'd0, 16'hBEEF, 16'hBEEF, TOTAL};
    applyStimulus(rv, 100, 1'b0, 1'b0);

    $display("[TB] wrt on done edge ignored, next cycle accepted");
    rv     = '{16'h1357, 2'b01, 2'd1, 16'h2468, 16'h2468, TOTAL};
    next_v = '{16'h9ABC, 2'b10, 2'd2, 16'hDEF0, 16'hDEF0, TOTAL};
    applyStimulus(rv, -1, 1'b1, 1'b0);
    checkOutput("done_edge_busy", 32'(busy), 32'd0);
    checkOutput("done_edge_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_done", 32'(done), 32'd0);
    applyStimulus(next_v, -1, 1'b0, 1'b1);

    $display("[TB] reset during bit 7");
    @(negedge clk);
    cmd = 16'hC3A5; mode = 2'b11; ss_sel = 2'd1; wrt = 1'b1;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    repeat (HALF + 7 * FULL + 4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ss_n", 32'(SS_n), 32'h7);
    checkOutput("midrst_sclk", 32'(SCLK), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv = '{16'h6E19, 2'b11, 2'd0, 16'hA0A5, 16'hA0A5, TOTAL};
    applyStimulus(rv, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
